iiitb_pwm_capture: RTL and testbench

Receive-side companion to the PWM generator. Samples an asynchronous PWM input and measures period and high time on the same `clk` domain. Reports duty cycle in 10 % steps (0–10), matching the generator's duty encoding. Detects a stuck line: no edge for a programmable number of cycles. Sits at the receiving end of a PWM link, or in a loopback checker for the generator's `PWM_OUT`.

---
 rtl/iiitb_pwm_capture.sv | 169 ++++++++++++++++
 tb/tb_iiitb_pwm_capture.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/iiitb_pwm_capture.sv
// PWM receiver: period/high-time/duty (0-10) per rise, stuck-line detect; PWM_CAP_GLITCH_FILTER_EN adds a 3-tap majority filter.
// Latency: strobe 3 clk after pwm_in first sampled high (+2 with filter); no backpressure, strobes are fire-and-forget.
module iiitb_pwm_capture #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 1000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic [3:0]       duty,
    output logic             meas_valid,
    output logic             stuck,
    output logic             stuck_level
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_MEASURE = 2'd1;
    localparam logic [1:0] ST_STUCK   = 2'd2;

    localparam int               DW        = CNT_W + 4;
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    logic             sync_1;
    logic             s;
    logic             f;
    logic             f_d;
    logic             rise;
    logic             fall;
    logic             edge_any;
    logic [CNT_W-1:0] per_cnt;
    logic [CNT_W-1:0] hi_cnt;
    logic [CNT_W-1:0] idle_cnt;
    logic [1:0]       state;
    logic             timeout_hit;
    logic             go_stuck;
    logic [DW-1:0]    hi_x10;
    logic [3:0]       duty_calc;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_1 <= 1'b0;
            s      <= 1'b0;
        end else begin
            sync_1 <= pwm_in;
            s      <= sync_1;
        end
    end

`ifdef PWM_CAP_GLITCH_FILTER_EN
    logic s_d1;
    logic s_d2;

    // Registered 2-of-3 vote: a one-cycle pulse never gets two votes.
    always_ff @(posedge clk) begin
        if (reset) begin
            s_d1 <= 1'b0;
            s_d2 <= 1'b0;
            f    <= 1'b0;
        end else begin
            s_d1 <= s;
            s_d2 <= s_d1;
            f    <= (s & s_d1) | (s & s_d2) | (s_d1 & s_d2);
        end
    end
`else
    assign f = s;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            f_d <= 1'b0;
        end else begin
            f_d <= f;
        end
    end

    assign rise     = f & ~f_d;
    assign fall     = ~f & f_d;
    assign edge_any = rise | fall;

    // The rise cycle itself is counted, so the value seen at the next rise is the full period.
    always_ff @(posedge clk) begin
        if (reset) begin
            per_cnt  <= '0;
            hi_cnt   <= '0;
            idle_cnt <= '0;
        end else begin
            if (rise) begin
                per_cnt <= CNT_ONE;
            end else if (per_cnt != CNT_MAX) begin
                per_cnt <= per_cnt + CNT_ONE;
            end

            if (rise) begin
                hi_cnt <= CNT_ONE;
            end else if (f && (hi_cnt != CNT_MAX)) begin
                hi_cnt <= hi_cnt + CNT_ONE;
            end

            if (edge_any) begin
                idle_cnt <= '0;
            end else if (idle_cnt != CNT_MAX) begin
                idle_cnt <= idle_cnt + CNT_ONE;
            end
        end
    end

    always_comb begin
        hi_x10    = (DW'(hi_cnt) << 3) + (DW'(hi_cnt) << 1);
        duty_calc = 4'd0;
        for (int d = 1; d <= 10; d++) begin
            if ((DW'(per_cnt) * DW'(d)) <= hi_x10) begin
                duty_calc = 4'(d);
            end
        end
    end

    assign timeout_hit = (idle_cnt == TIMEOUT_C);
    // A rise in the same cycle as the timeout proves the line is alive.
    assign go_stuck    = (state != ST_STUCK) && timeout_hit && !rise;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            period      <= '0;
            high_time   <= '0;
            duty        <= 4'd0;
            meas_valid  <= 1'b0;
            stuck       <= 1'b0;
            stuck_level <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            if (go_stuck) begin
                state       <= ST_STUCK;
                stuck       <= 1'b1;
                stuck_level <= f;
                period      <= '0;
                high_time   <= '0;
                duty        <= f ? 4'd10 : 4'd0;
                meas_valid  <= 1'b1;
            end else if (rise) begin
                case (state)
                    ST_IDLE: begin
                        state <= ST_MEASURE;
                    end
                    ST_MEASURE: begin
                        period     <= per_cnt;
                        high_time  <= hi_cnt;
                        duty       <= duty_calc;
                        meas_valid <= 1'b1;
                    end
                    ST_STUCK: begin
                        state       <= ST_MEASURE;
                        stuck       <= 1'b0;
                        stuck_level <= 1'b0;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_iiitb_pwm_capture.sv
// Directed bench for iiitb_pwm_capture (CNT_W=16, TIMEOUT=50); expectations adapt to PWM_CAP_GLITCH_FILTER_EN.
// Strobes are logged on the falling edge and compared against hand-computed values.
module tb_iiitb_pwm_capture;

`ifdef PWM_CAP_GLITCH_FILTER_EN
    localparam int FLT = 2;
`else
    localparam int FLT = 0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        pwm_in;
    logic [15:0] period;
    logic [15:0] high_time;
    logic [3:0]  duty;
    logic        meas_valid;
    logic        stuck;
    logic        stuck_level;

    int checks = 0;
    int errors = 0;
    int cyc_n  = 0;

    typedef struct {
        int per;
        int hi;
        int dty;
        int stk;
        int lvl;
        int cyc;
    } strobe_t;

    strobe_t sq[$];

    iiitb_pwm_capture #(
        .CNT_W   (16),
        .TIMEOUT (50)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pwm_in      (pwm_in),
        .period      (period),
        .high_time   (high_time),
        .duty        (duty),
        .meas_valid  (meas_valid),
        .stuck       (stuck),
        .stuck_level (stuck_level)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    always @(negedge clk) begin
        if (meas_valid === 1'b1) begin
            strobe_t e;
            e.per = int'(period);
            e.hi  = int'(high_time);
            e.dty = int'(duty);
            e.stk = int'(stuck);
            e.lvl = int'(stuck_level);
            e.cyc = cyc_n;
            sq.push_back(e);
        end
    end

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic exp_strobe(input string tag, input int i, input int per, input int hi,
                              input int dty, input int stk, input int lvl);
        chk($sformatf("%s%0d_present", tag, i), (sq.size() > i) ? 1 : 0, 1);
        if (sq.size() > i) begin
            chk($sformatf("%s%0d_period", tag, i), sq[i].per, per);
            chk($sformatf("%s%0d_high", tag, i), sq[i].hi, hi);
            chk($sformatf("%s%0d_duty", tag, i), sq[i].dty, dty);
            chk($sformatf("%s%0d_stuck", tag, i), sq[i].stk, stk);
            chk($sformatf("%s%0d_level", tag, i), sq[i].lvl, lvl);
        end
    endtask

    task automatic cyc(input logic v);
        pwm_in = v;
        #10;
    endtask

    task automatic pulse(input int h, input int p);
        repeat (h) cyc(1'b1);
        repeat (p - h) cyc(1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc(1'b0);
        cyc(1'b0);
        reset = 1'b0;
        repeat (3) cyc(1'b0);
        sq.delete();
    endtask

    initial begin
        int t_ref;

        reset  = 1'b1;
        pwm_in = 1'b0;
        @(posedge clk);
        #2;
        repeat (3) cyc(1'b0);
        chk("rst_period", period, 0);
        chk("rst_high", high_time, 0);
        chk("rst_duty", duty, 0);
        chk("rst_valid", meas_valid, 0);
        chk("rst_stuck", stuck, 0);
        chk("rst_level", stuck_level, 0);
        reset = 1'b0;
        repeat (3) cyc(1'b0);
        sq.delete();

        // 10/5 then 10/9, then the line dies low
        t_ref = 0;
        for (int p = 0; p < 4; p++) begin
            if (p == 1) t_ref = cyc_n;
            pulse(5, 10);
        end
        pulse(9, 10);
        pulse(9, 10);
        repeat (9) cyc(1'b1);
        chk("s1_count_before_stuck", sq.size(), 6);
        if (sq.size() > 1) begin
            chk("s1_first_latency", sq[0].cyc - t_ref, 3 + FLT);
            chk("s1_spacing", sq[1].cyc - sq[0].cyc, 10);
        end
        t_ref = cyc_n;
        repeat (71) cyc(1'b0);
        chk("s1_count", sq.size(), 7);
        for (int i = 0; i < 4; i++) exp_strobe("s1_d5_", i, 10, 5, 5, 0, 0);
        for (int i = 4; i < 6; i++) exp_strobe("s1_d9_", i, 10, 9, 9, 0, 0);
        exp_strobe("s1_stuck_", 6, 0, 0, 0, 1, 0);
        if (sq.size() > 6) chk("s1_stuck_latency", sq[6].cyc - t_ref, 54 + FLT);
        chk("s1_stuck_now", stuck, 1);
        chk("s1_level_now", stuck_level, 0);
        chk("s1_valid_low", meas_valid, 0);

        // line held high
        sq.delete();
        t_ref = cyc_n;
        repeat (60) cyc(1'b1);
        chk("s2_count", sq.size(), 1);
        exp_strobe("s2_hi_", 0, 0, 0, 10, 1, 1);
        if (sq.size() > 0) chk("s2_stuck_latency", sq[0].cyc - t_ref, 54 + FLT);
        chk("s2_level_now", stuck_level, 1);
        chk("s2_duty_now", duty, 10);
        sq.delete();
        repeat (13) cyc(1'b0);
        chk("s2_fall_ignored_stuck", stuck, 1);
        chk("s2_fall_ignored_level", stuck_level, 1);
        pulse(7, 20);
        chk("s2_recover_stuck", stuck, 0);
        chk("s2_recover_level", stuck_level, 0);
        chk("s2_recover_nostrobe", sq.size(), 0);
        pulse(7, 20);
        pulse(7, 20);
        chk("s2_count_after", sq.size(), 2);
        exp_strobe("s2_p20_", 0, 20, 7, 3, 0, 0);
        exp_strobe("s2_p20_", 1, 20, 7, 3, 0, 0);

        // reset in the middle of a high phase
        pulse(5, 10);
        pulse(5, 10);
        cyc(1'b1);
        cyc(1'b1);
        chk("s3_pre_period", period, 10);
        reset = 1'b1;
        cyc(1'b0);
        chk("s3_rst_period", period, 0);
        chk("s3_rst_high", high_time, 0);
        chk("s3_rst_duty", duty, 0);
        chk("s3_rst_valid", meas_valid, 0);
        chk("s3_rst_stuck", stuck, 0);
        chk("s3_rst_level", stuck_level, 0);
        reset = 1'b0;
        repeat (3) cyc(1'b0);
        sq.delete();
        repeat (3) pulse(5, 10);
        chk("s3_count", sq.size(), 2);
        exp_strobe("s3_", 0, 10, 5, 5, 0, 0);
        exp_strobe("s3_", 1, 10, 5, 5, 0, 0);

        // one-cycle glitch inside a low phase
        do_reset();
        pulse(5, 10);
        pulse(5, 10);
        repeat (5) cyc(1'b1);
        cyc(1'b0);
        cyc(1'b0);
        cyc(1'b1);
        cyc(1'b0);
        cyc(1'b0);
        pulse(5, 10);
        cyc(1'b1);
        repeat (8) cyc(1'b0);
`ifdef PWM_CAP_GLITCH_FILTER_EN
        chk("s4_count", sq.size(), 4);
        for (int i = 0; i < 4; i++) exp_strobe("s4_", i, 10, 5, 5, 0, 0);
`else
        chk("s4_count", sq.size(), 5);
        exp_strobe("s4_", 0, 10, 5, 5, 0, 0);
        exp_strobe("s4_", 1, 10, 5, 5, 0, 0);
        exp_strobe("s4_", 2, 7, 5, 7, 0, 0);
        exp_strobe("s4_", 3, 3, 1, 3, 0, 0);
        exp_strobe("s4_", 4, 10, 5, 5, 0, 0);
`endif

        // longer period, input changing at an odd clock phase
        do_reset();
        #5;
        repeat (4) pulse(20, 60);
        chk("s5_count", sq.size(), 3);
        for (int i = 0; i < 3; i++) exp_strobe("s5_", i, 60, 20, 3, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
